// File: rtl/burst_replay_pkg.sv
// Shared types and default widths for the burst capture/replay buffer.
package burst_replay_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int REP_W  = 4;
  localparam int DEPTH  = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, DRAIN} brb_state_e;
endpackage

// File: rtl/brb_sync_ram.sv
// Single-port RAM, synchronous write, registered read data (no reset on storage).
module brb_sync_ram #(
  parameter int DATA_W = burst_replay_pkg::DATA_W,
  parameter int ADDR_W = burst_replay_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/burst_replay_buffer.sv
// Captures one in_valid burst into RAM and replays it (in_repeat+1) times back to back.
// Optional BURST_REPLAY_REVERSE_EN adds in_reverse for descending-address playback.
module burst_replay_buffer #(
  parameter int DATA_W = burst_replay_pkg::DATA_W,
  parameter int ADDR_W = burst_replay_pkg::ADDR_W,
  parameter int REP_W  = burst_replay_pkg::REP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REP_W-1:0]  in_repeat,
`ifdef BURST_REPLAY_REVERSE_EN
  input  logic              in_reverse,
`endif
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              ovf
);
  import burst_replay_pkg::*;

  localparam int STAGES = 1;

  brb_state_e        state, state_nxt;
  logic [ADDR_W:0]   len;
  logic [REP_W-1:0]  rep, pass;
  logic [ADDR_W-1:0] rd_ptr, last_ptr, first_ptr, end_ptr;
  logic              full, at_end, final_rd, rev;
  logic              ram_we, rd_issue;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [STAGES:0]   vld_pipe, last_pipe;

`ifdef BURST_REPLAY_REVERSE_EN
  always_ff @(posedge clk) begin
    if (rst)                          rev <= 1'b0;
    else if (state == IDLE && in_valid) rev <= in_reverse;
  end
`else
  assign rev = 1'b0;
`endif

  // len never exceeds DEPTH, so its MSB alone marks a full buffer
  assign full      = len[ADDR_W];
  assign last_ptr  = ADDR_W'(len - 1'b1);
  assign first_ptr = rev ? last_ptr : '0;
  assign end_ptr   = rev ? '0 : last_ptr;
  assign at_end    = (rd_ptr == end_ptr);
  assign final_rd  = (state == REPLAY) && at_end && (pass == rep);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN holds one cycle: its exit edge is the one moving the final word onto out_data
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CAPTURE;
      CAPTURE: if (!in_valid) state_nxt = REPLAY;
      REPLAY:  if (final_rd)  state_nxt = DRAIN;
      DRAIN:                  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    ram_addr = len[ADDR_W-1:0];
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        ram_we   = in_valid;
        ram_addr = '0;
      end
      CAPTURE: begin
        in_ready = 1'b1;
        ram_we   = in_valid && !full;
      end
      REPLAY: begin
        rd_issue = 1'b1;
        ram_addr = rd_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len    <= '0;
      rep    <= '0;
      pass   <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          len <= (ADDR_W+1)'(1);
          rep <= in_repeat;
          ovf <= 1'b0;
        end
        CAPTURE: begin
          if (in_valid) begin
            if (!full) len <= len + 1'b1;
            else       ovf <= 1'b1;
          end else begin
            rd_ptr <= first_ptr;
            pass   <= '0;
          end
        end
        REPLAY: begin
          if (at_end) begin
            rd_ptr <= first_ptr;
            pass   <= pass + 1'b1;
          end else begin
            rd_ptr <= rev ? rd_ptr - 1'b1 : rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  brb_sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (in_data),
    .rdata (ram_rdata)
  );

  // stage 0 aligns with RAM read data, stage 1 with the out_data register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      out_data  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], rd_issue};
      last_pipe <= {last_pipe[STAGES-1:0], final_rd};
      out_data  <= vld_pipe[0] ? ram_rdata : '0;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_last  = last_pipe[STAGES];
endmodule

// File: tb/tb_burst_replay_buffer.sv
// Scoreboard bench for burst_replay_buffer with an 8-deep buffer.
module tb_burst_replay_buffer;
  localparam int DW = 16, AW = 3, RW = 4, DEPTH = 8;

  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_repeat = '0;
`ifdef BURST_REPLAY_REVERSE_EN
  logic          in_reverse = 1'b0;
`endif
  logic          in_ready, out_valid, out_last, ovf;
  logic [DW-1:0] out_data;

  int checks = 0, errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] burst_q[$];
  logic          prev_mid = 1'b0;

  burst_replay_buffer #(.DATA_W(DW), .ADDR_W(AW), .REP_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_repeat (in_repeat),
`ifdef BURST_REPLAY_REVERSE_EN
    .in_reverse(in_reverse),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor: pops the scoreboard and checks gap-free delivery
  always @(negedge clk) begin
    if (rst) prev_mid = 1'b0;
    else begin
      if (prev_mid) chk("gap", {31'b0, out_valid}, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", {31'b0, out_valid}, 0);
        else chk("out", {15'b0, out_last, out_data}, {15'b0, exp_q.pop_front()});
      end else begin
        chk("idle_out", {15'b0, out_last, out_data}, 0);
      end
      prev_mid = out_valid && !out_last;
    end
  end

  task automatic push_exp(input int rep, input bit rev);
    int n;
    n = (burst_q.size() > DEPTH) ? DEPTH : burst_q.size();
    for (int p = 0; p <= rep; p++)
      for (int i = 0; i < n; i++)
        exp_q.push_back({(p == rep) && (i == n - 1), burst_q[rev ? n - 1 - i : i]});
  endtask

  task automatic send(input int rep, input bit rev);
    push_exp(rep, rev);
    for (int i = 0; i < burst_q.size(); i++) begin
      in_valid  = 1'b1;
      in_data   = burst_q[i];
      in_repeat = RW'(rep);
`ifdef BURST_REPLAY_REVERSE_EN
      in_reverse = rev;
`endif
      @(posedge clk); #1;
      chk("ovf_capture", {31'b0, ovf}, {31'b0, i >= DEPTH});
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ready_idle", {31'b0, in_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data",  {16'b0, out_data}, 0);
    chk("rst_last",  {31'b0, out_last}, 0);
    chk("rst_ovf",   {31'b0, ovf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic burst and read latency
    burst_q = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5};
    send(0, 0);
    @(posedge clk); #1; chk("lat_e0", {31'b0, out_valid}, 0);
    @(posedge clk); #1; chk("lat_e1", {31'b0, out_valid}, 0);
    chk("ready_replay", {31'b0, in_ready}, 0);
    @(posedge clk); #1; chk("lat_e2", {31'b0, out_valid}, 1);
    wait_drain();
    chk("ovf_none", {31'b0, ovf}, 0);

    // repeated passes
    burst_q = '{16'hA, 16'hB, 16'hC};
    send(2, 0);
    wait_drain();

    // overflow: 10 words into 8 slots
    burst_q = '{};
    for (int i = 0; i < 10; i++) burst_q.push_back(DW'(i));
    send(0, 0);
    wait_drain();
    chk("ovf_hold", {31'b0, ovf}, 1);

    // single word, then a burst started in the out_last cycle
    burst_q = '{16'h1234};
    send(0, 0);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!out_last && n < 50);
      chk("last_seen", {31'b0, out_last}, 1);
    end
    chk("ready_b2b", {31'b0, in_ready}, 1);
    burst_q = '{16'h55};
    push_exp(0, 0);
    in_valid = 1'b1; in_data = 16'h55; in_repeat = '0;
    @(posedge clk); #1;
    chk("ovf_cleared", {31'b0, ovf}, 0);
    in_valid = 1'b0; in_data = '0;
    wait_drain();

    // input offered during replay is ignored
    burst_q = '{16'h1, 16'h2, 16'h3, 16'h4};
    send(3, 0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'hFFFF;
      chk("ready_busy", {31'b0, in_ready}, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    chk("no_ghost", {31'b0, out_valid}, 0);

    // reset mid-replay
    burst_q = '{};
    for (int i = 0; i < 10; i++) burst_q.push_back(DW'(16'h100 + i));
    send(1, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    chk("pre_rst_ovf", {31'b0, ovf}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_data",  {16'b0, out_data}, 0);
    chk("mid_rst_ready", {31'b0, in_ready}, 1);
    chk("mid_rst_ovf",   {31'b0, ovf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    burst_q = '{16'h7, 16'h8};
    send(0, 0);
    wait_drain();

`ifdef BURST_REPLAY_REVERSE_EN
    burst_q = '{16'h1, 16'h2, 16'h3};
    send(1, 1);
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
